// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
//
// Handshake: a request is transferred on every rising edge where
// IMemReq && IMemGnt. Once IMemReq is raised, IMemReq and IMemAddr are held
// stable until the grant. The one exception is a redirect, which withdraws
// an ungranted request. A response is transferred on every rising edge
// where IMemRValid is high. Responses carry no ready signal: the fetch
// unit issues a request only when it has space for the matching response.
// Responses return in request order, at least one cycle after their grant.
//
// Signals:
//   IMemReq     fetch -> mem  request valid
//   IMemAddr    fetch -> mem  word-aligned request address
//   IMemGnt     mem -> fetch  request accepted this cycle
//   IMemRValid  mem -> fetch  response valid
//   IMemRData   mem -> fetch  response instruction word
interface instr_fetch_unit_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRValid;
  logic [31:0] IMemRData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemGnt,
    input  IMemRValid,
    input  IMemRData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemGnt,
    output IMemRValid,
    output IMemRData
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline registers.
//
// The unit owns the fetch PC and issues word-aligned requests to a
// variable-latency instruction memory. Returned words are buffered in an
// in-order FIFO together with their PCs. The FIFO head is presented to
// IF/ID. A redirect from EX restarts fetch at the target. Responses still
// in flight from the old path are counted and discarded as they return.
//
// Parameters:
//   DEPTH     FIFO entries and the maximum number of outstanding requests
//             (power of two, 2..8)
//   RESET_PC  fetch PC after reset
//   NOP       instruction word driven while nothing valid is at the head
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   StallF     IF/ID hold; the head is not consumed while high
//   PCSrcE     redirect strobe from EX
//   PCTargetE  redirect target (bits [1:0] ignored)
//   imem       instruction-memory bus (master side)
//   InstrF     head instruction, or NOP when empty
//   PCF        head PC, or 0 when empty
//   PCPlus4F   PCF + 4, or 0 when empty
//   ValidF     head valid
//
// Build option:
//   FETCH_BYPASS_EN  when defined, a response that arrives while the FIFO is
//                    empty and nothing is being discarded is presented on
//                    the outputs in the same cycle. It is consumed directly
//                    if StallF is low, and otherwise it is buffered as usual.
module instr_fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    StallF,
  input  logic                    PCSrcE,
  input  logic [31:0]             PCTargetE,
  instr_fetch_unit_if.master      imem,
  output logic [31:0]             InstrF,
  output logic [31:0]             PCF,
  output logic [31:0]             PCPlus4F,
  output logic                    ValidF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DepthL = DEPTH[CW:0];

  logic [31:0]   fetchPc;
  // Low during reset and for the first cycle after it. No request is
  // issued until the first clock edge after reset is released.
  logic          running;
  logic [CW-1:0] outCnt;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] count;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] tagRd;
  logic [PW-1:0] tagWr;

  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];
  // Holds the PCs of the correct-path requests that are still outstanding,
  // in issue order.
  logic [31:0]   tagMem   [DEPTH];

  logic          credit;
  logic          grant;
  logic          rsp;
  logic          dropping;
  logic          acceptRsp;
  logic          headValid;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [CW-1:0] outNext;

  // Reserve a FIFO slot for every request in flight, so that a response
  // never finds the FIFO full.
  assign credit = ({1'b0, outCnt} + {1'b0, count}) < DepthL;

  assign imem.IMemReq  = running & ~PCSrcE & credit;
  assign imem.IMemAddr = fetchPc;

  assign grant     = imem.IMemReq & imem.IMemGnt;
  assign rsp       = imem.IMemRValid;
  assign dropping  = (dropCnt != '0);
  assign acceptRsp = rsp & ~dropping & ~PCSrcE;
  assign headValid = (count != '0);
  assign outNext   = outCnt + CW'(grant) - CW'(rsp);

`ifdef FETCH_BYPASS_EN
  assign bypass = ~headValid & acceptRsp;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = headValid & ~StallF;
  // A bypassed response that IF/ID takes immediately is not stored.
  assign push = acceptRsp & ~(bypass & ~StallF);

  always_comb begin
    InstrF = NOP;
    PCF    = 32'd0;
    if (headValid) begin
      InstrF = instrMem[rdPtr];
      PCF    = pcMem[rdPtr];
    end else if (bypass) begin
      InstrF = imem.IMemRData;
      PCF    = tagMem[tagRd];
    end
  end

  assign ValidF   = headValid | bypass;
  assign PCPlus4F = ValidF ? (PCF + 32'd4) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc <= RESET_PC;
      running <= 1'b0;
      outCnt  <= '0;
      dropCnt <= '0;
      count   <= '0;
      rdPtr   <= '0;
      wrPtr   <= '0;
      tagRd   <= '0;
      tagWr   <= '0;
    end else begin
      running <= 1'b1;
      if (PCSrcE) begin
        // Everything still outstanding after this edge belongs to the old
        // path. The response arriving now is already excluded by outNext.
        fetchPc <= PCTargetE & ~32'd3;
        outCnt  <= outNext;
        dropCnt <= outNext;
        count   <= '0;
        rdPtr   <= '0;
        wrPtr   <= '0;
        tagRd   <= '0;
        tagWr   <= '0;
      end else begin
        outCnt <= outNext;
        count  <= count + CW'(push) - CW'(pop);
        if (grant) begin
          fetchPc <= fetchPc + 32'd4;
          tagWr   <= tagWr + PW'(1);
        end
        if (acceptRsp) begin
          tagRd <= tagRd + PW'(1);
        end
        if (rsp && dropping) begin
          dropCnt <= dropCnt - CW'(1);
        end
        if (push) begin
          wrPtr <= wrPtr + PW'(1);
        end
        if (pop) begin
          rdPtr <= rdPtr + PW'(1);
        end
      end
    end
  end

  // Storage needs no reset. The pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imem.IMemRData;
      pcMem[wrPtr]    <= tagMem[tagRd];
    end
    if (grant) begin
      tagMem[tagWr] <= fetchPc;
    end
  end

endmodule
